// File: rtl/mem_io_responder_pkg.sv
// Shared constants, byte type and I/O window decode for the memory/I-O responder.
package mem_io_responder_pkg;

  typedef logic [7:0] BYTE_TP;

  localparam logic [17:0] IO_PORT_ADDR  = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR   = 18'h30004;
  localparam logic [17:0] IO_SNAP1_ADDR = 18'h30005;
  localparam logic [17:0] IO_SNAP2_ADDR = 18'h30006;
  localparam logic [17:0] IO_SNAP3_ADDR = 18'h30007;

  // The I/O window is the top quarter of the 18-bit decoded space (bits [17:16] == 2'b11).
  function automatic logic is_io_addr(input logic [17:0] a);
    return a >= 18'h30000;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU RAM bus: memctrl is the master, the responder is the slave.
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  logic [31:0] mem_a;
  logic        mem_wr;
  BYTE_TP      mem_din;
  BYTE_TP      mem_dout;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_wr, mem_din,
    input  mem_dout, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_wr, mem_din,
    output mem_dout, io_buffer_full
  );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Show-ahead byte FIFO; pointers carry one extra wrap bit so full and empty differ.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  BYTE_TP                   push_data,
  input  logic                     pop,
  output BYTE_TP                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  BYTE_TP           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == PTR_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so a full FIFO may still accept the push.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && rst_in) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// RAM plus memory-mapped UART FIFOs, cycle counter and program-stop flag on the CPU byte bus.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mem_io_responder_if.slave   bus,
  output logic                tx_valid,
  output BYTE_TP              tx_data,
  input  logic                tx_ready,
  input  logic                rx_valid,
  input  BYTE_TP              rx_data,
  output logic                program_done,
  output logic                tx_overflow
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [17:0]           io_a;
  logic                  sel_io;
  logic                  io_wr;
  logic                  io_rd;
  logic [RAM_ADDR_W-1:0] ram_a;
  logic                  ram_we;
  logic                  ram_re;

  BYTE_TP                ram [2**RAM_ADDR_W];
  BYTE_TP                ram_q;
  BYTE_TP                io_q;
  BYTE_TP                io_rdata;
  logic                  rd_from_io;
  logic                  io_full_q;
  logic [31:0]           cycle_cnt;
  logic [23:0]           snap_hi;

  logic                  tx_push;
  BYTE_TP                tx_push_data;
  logic                  tx_pop;
  logic                  tx_full;
  logic                  tx_empty;
  logic [TX_CW-1:0]      tx_count;
  logic                  rx_pop;
  logic                  rx_full;
  logic                  rx_empty;
  logic [RX_CW-1:0]      rx_count;
  BYTE_TP                rx_head;
  logic                  unused_bits;

  assign io_a   = bus.mem_a[17:0];
  assign sel_io = is_io_addr(io_a);
  assign io_wr  = bus.mem_wr && sel_io;
  assign io_rd  = !bus.mem_wr && sel_io;
  assign ram_a  = bus.mem_a[RAM_ADDR_W-1:0];
  assign ram_we = rst_in && bus.mem_wr && !sel_io;
  assign ram_re = !bus.mem_wr && !sel_io;

  // 0x00 on the port is swallowed; the program-done write deliberately queues a 0x00.
  assign tx_push      = io_wr && (((io_a == IO_PORT_ADDR) && (bus.mem_din != 8'h00))
                                  || (io_a == IO_CLK_ADDR));
  assign tx_push_data = (io_a == IO_CLK_ADDR) ? 8'h00 : bus.mem_din;
  assign tx_valid     = !tx_empty;
  assign tx_pop       = tx_valid && tx_ready;
  assign rx_pop       = io_rd && (io_a == IO_PORT_ADDR);

  assign bus.mem_dout       = rd_from_io ? io_q : ram_q;
  assign bus.io_buffer_full = io_full_q;
  assign unused_bits        = ^{bus.mem_a[31:18], rx_count, rx_full, rx_empty};

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_data),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // RAM is never reset so preloaded contents survive; the read port only updates on RAM reads.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_a] <= bus.mem_din;
    if (ram_re) ram_q <= ram[ram_a];
  end

  always_comb begin
    io_rdata = 8'h00;
    case (io_a)
      IO_PORT_ADDR:  io_rdata = rx_head;
      IO_CLK_ADDR:   io_rdata = cycle_cnt[7:0];
      IO_SNAP1_ADDR: io_rdata = snap_hi[7:0];
      IO_SNAP2_ADDR: io_rdata = snap_hi[15:8];
      IO_SNAP3_ADDR: io_rdata = snap_hi[23:16];
      default:       io_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cycle_cnt    <= '0;
      snap_hi      <= '0;
      io_q         <= 8'h00;
      rd_from_io   <= 1'b1;
      io_full_q    <= 1'b0;
      program_done <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      io_full_q <= (tx_count >= TX_CW'(TX_DEPTH - FULL_MARGIN));
      if (!bus.mem_wr) rd_from_io <= sel_io;
      if (io_rd) io_q <= io_rdata;
      if (io_rd && (io_a == IO_CLK_ADDR)) snap_hi <= cycle_cnt[31:8];
      if (io_wr && (io_a == IO_CLK_ADDR)) program_done <= 1'b1;
      if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: queue-based reference model, per-cycle monitor.
module tb_mem_io_responder;

  localparam int TX_DEPTH    = 16;
  localparam int RX_DEPTH    = 16;
  localparam int FULL_MARGIN = 2;

  typedef struct {
    bit         tx_check;
    bit         tx_valid;
    bit         tx_zero;
    logic [7:0] tx_data;
    bit         rd_check;
    logic [7:0] rd_exp;
    bit         done;
    bit         ovf;
    bit         full;
  } rec_t;

  logic       clk_in;
  logic       rst_in;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       program_done;
  logic       tx_overflow;

  mem_io_responder_if bus();

  mem_io_responder #(
    .RAM_ADDR_W  (17),
    .TX_DEPTH    (TX_DEPTH),
    .RX_DEPTH    (RX_DEPTH),
    .FULL_MARGIN (FULL_MARGIN)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .bus          (bus),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .program_done (program_done),
    .tx_overflow  (tx_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model state
  logic [7:0]  ram_m [int];
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  rec_t        rec_q [$];
  logic [31:0] cyc_m = 32'd0;
  logic [31:0] snap_m = 32'd0;
  logic [7:0]  dout_m = 8'h00;
  bit          dout_known = 1'b0;
  bit          done_m = 1'b0;
  bit          ovf_m = 1'b0;
  bit          model_known = 1'b0;
  bit          just_reset = 1'b0;

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic txPush(input logic [7:0] b);
    if (tx_q.size() < TX_DEPTH) tx_q.push_back(b);
    else ovf_m = 1'b1;
  endtask

  // One bus cycle: drive at the falling edge, then advance the model across the next rising edge.
  task automatic applyStimulus(input bit rst_n, input bit wr, input logic [31:0] a,
                               input logic [7:0] d, input bit txr, input bit rxv,
                               input logic [7:0] rxd);
    rec_t        r;
    int          pre_size;
    logic [17:0] off;
    logic [31:0] at_edge;
    @(negedge clk_in);
    rst_in      = rst_n;
    bus.mem_wr  = wr;
    bus.mem_a   = a;
    bus.mem_din = d;
    tx_ready    = txr;
    rx_valid    = rxv;
    rx_data     = rxd;

    off        = a[17:0];
    pre_size   = tx_q.size();
    r.tx_check = model_known;
    r.tx_valid = (pre_size > 0);
    r.tx_data  = (pre_size > 0) ? tx_q[0] : 8'h00;
    r.tx_zero  = just_reset;
    r.full     = 1'b0;
    just_reset = 1'b0;

    if (!rst_n) begin
      tx_q.delete();
      rx_q.delete();
      done_m      = 1'b0;
      ovf_m       = 1'b0;
      cyc_m       = 32'd0;
      snap_m      = 32'd0;
      dout_m      = 8'h00;
      dout_known  = 1'b1;
      model_known = 1'b1;
      just_reset  = 1'b1;
    end else begin
      at_edge = cyc_m;
      cyc_m   = cyc_m + 32'd1;
      r.full  = (pre_size >= TX_DEPTH - FULL_MARGIN);
      if (txr && pre_size > 0) void'(tx_q.pop_front());
      if (off >= 18'h30000) begin
        if (wr) begin
          if (off == 18'h30000 && d != 8'h00) txPush(d);
          else if (off == 18'h30004) begin
            done_m = 1'b1;
            txPush(8'h00);
          end
        end else begin
          dout_known = 1'b1;
          case (off)
            18'h30000: dout_m = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
            18'h30004: begin
              dout_m = at_edge[7:0];
              snap_m = at_edge;
            end
            18'h30005: dout_m = snap_m[15:8];
            18'h30006: dout_m = snap_m[23:16];
            18'h30007: dout_m = snap_m[31:24];
            default:   dout_m = 8'h00;
          endcase
        end
      end else if (wr) begin
        ram_m[int'(a[16:0])] = d;
      end else if (ram_m.exists(int'(a[16:0]))) begin
        dout_m     = ram_m[int'(a[16:0])];
        dout_known = 1'b1;
      end else begin
        dout_known = 1'b0;
      end
      if (rxv && rx_q.size() < RX_DEPTH) rx_q.push_back(rxd);
    end

    r.rd_check = dout_known;
    r.rd_exp   = dout_m;
    r.done     = done_m;
    r.ovf      = ovf_m;
    rec_q.push_back(r);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [7:0] d, input bit txr);
    applyStimulus(1'b1, 1'b1, a, d, txr, 1'b0, 8'h00);
  endtask

  task automatic busRead(input logic [31:0] a, input bit txr);
    applyStimulus(1'b1, 1'b0, a, 8'h00, txr, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n, input bit txr);
    for (int i = 0; i < n; i++) busRead(32'h0000_0010, txr);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: pre-edge TX handshake of this cycle, post-edge outputs of the previous cycle.
  rec_t cur;
  rec_t prev;
  bit   have_prev = 1'b0;

  always begin
    @(negedge clk_in);
    #1;
    if (have_prev) begin
      if (prev.rd_check) checkOutput("mem_dout", {24'h0, bus.mem_dout}, {24'h0, prev.rd_exp});
      checkOutput("program_done", {31'h0, program_done}, {31'h0, prev.done});
      checkOutput("tx_overflow", {31'h0, tx_overflow}, {31'h0, prev.ovf});
      checkOutput("io_buffer_full", {31'h0, bus.io_buffer_full}, {31'h0, prev.full});
    end
    if (rec_q.size() > 0) begin
      cur = rec_q.pop_front();
      if (cur.tx_check) begin
        checkOutput("tx_valid", {31'h0, tx_valid}, {31'h0, cur.tx_valid});
        if (cur.tx_valid || cur.tx_zero)
          checkOutput("tx_data", {24'h0, tx_data}, {24'h0, cur.tx_data});
      end
      prev      = cur;
      have_prev = 1'b1;
    end else begin
      have_prev = 1'b0;
    end
  end

  logic [31:0] ra;
  logic [7:0]  rd;
  int          op;

  initial begin
    rst_in      = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.mem_a   = 32'h0;
    bus.mem_din = 8'h00;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;

    doReset(2);
    busWrite(32'h0000_0010, 8'hA5, 1'b0);
    busRead(32'h0000_0010, 1'b0);
    busWrite(32'h0001_FFFF, 8'h3C, 1'b0);
    busRead(32'h0001_FFFF, 1'b0);
    busWrite(32'h0000_0011, 8'h77, 1'b0);

    busWrite(32'h0003_0000, 8'h41, 1'b1);
    busWrite(32'h0003_0000, 8'h00, 1'b1);
    busWrite(32'h0003_0000, 8'h42, 1'b1);
    idle(4, 1'b1);

    for (int i = 1; i <= 17; i++) busWrite(32'h0003_0000, 8'(i), 1'b0);
    idle(3, 1'b0);
    idle(20, 1'b1);

    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0, 1'b1, 8'h55);
    busRead(32'h0003_0000, 1'b0);
    busRead(32'h0003_0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h66);
    busRead(32'h0003_0000, 1'b0);

    doReset(1);
    idle(32'h1234, 1'b0);
    busRead(32'h0003_0004, 1'b0);
    busRead(32'h0003_0005, 1'b0);
    busRead(32'h0003_0006, 1'b0);
    busRead(32'h0003_0007, 1'b0);

    busWrite(32'h0003_0004, 8'h99, 1'b0);
    idle(2, 1'b0);
    doReset(1);
    idle(2, 1'b0);
    busRead(32'h0000_0010, 1'b0);

    for (int n = 0; n < 800; n++) begin
      op = $urandom_range(0, 10);
      rd = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       ra = 32'h0000_0010;
        1:       ra = 32'h0001_FFFF;
        default: ra = {15'h0, 17'($urandom)};
      endcase
      if ($urandom_range(0, 199) == 0) begin
        doReset(1);
      end else begin
        case (op)
          0, 1: applyStimulus(1'b1, 1'b1, ra, rd, 1'($urandom),
                              ($urandom_range(0, 2) == 0), 8'($urandom));
          2, 3: applyStimulus(1'b1, 1'b0, ra, 8'h00, 1'($urandom),
                              ($urandom_range(0, 2) == 0), 8'($urandom));
          4:    applyStimulus(1'b1, 1'b1, 32'h0003_0000,
                              ($urandom_range(0, 3) == 0) ? 8'h00 : rd,
                              ($urandom_range(0, 3) == 0), 1'b0, 8'h00);
          5:    applyStimulus(1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'($urandom),
                              1'($urandom), 8'($urandom));
          6:    busRead(32'h0003_0004 + 32'($urandom_range(0, 3)), 1'($urandom));
          7:    if ($urandom_range(0, 7) == 0) busWrite(32'h0003_0004, rd, 1'($urandom));
                else busRead(32'h0003_0004, 1'($urandom));
          8:    applyStimulus(1'b1, 1'($urandom), 32'h0003_0000 | 32'($urandom_range(0, 65535)),
                              rd, 1'($urandom), 1'($urandom), 8'($urandom));
          default: applyStimulus(1'b1, 1'($urandom), {14'($urandom), ra[17:0] & 18'h1FFFF},
                                 rd, 1'($urandom), 1'b0, 8'h00);
        endcase
      end
    end

    idle(2, 1'b0);
    repeat (2) @(negedge clk_in);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
